// File: rtl/motor_guard_if.sv
// Signal bundle between the PWM/switch side and the motor_guard output stage.
// The guard consumes pulse, switches and comparators and drives the bridge pins and status.
interface motor_guard_if;
  logic       pulse;
  logic       en_sw;
  logic       fwd_sw;
  logic       bwd_sw;
  logic       comp_a;
  logic       comp_b;
  logic       ena;
  logic       enb;
  logic [3:0] hb_in;
  logic [2:0] state;
  logic [1:0] dir;
  logic       oc_now;
  logic       fault;
  logic       lockout;

  modport master (
    output pulse, en_sw, fwd_sw, bwd_sw, comp_a, comp_b,
    input  ena, enb, hb_in, state, dir, oc_now, fault, lockout
  );

  modport slave (
    input  pulse, en_sw, fwd_sw, bwd_sw, comp_a, comp_b,
    output ena, enb, hb_in, state, dir, oc_now, fault, lockout
  );
endinterface

// File: rtl/motor_guard.sv
// H-bridge output guard: dead-time on reversal/stop, filtered overcurrent cutoff,
// cooldown retry and lockout after repeated faults. All outputs are registered.
module motor_guard #(
  parameter int DEADTIME_CYCLES = 100000,
  parameter int FILTER_CYCLES   = 8,
  parameter int COOLDOWN_CYCLES = 50000000,
  parameter int MAX_RETRIES     = 3
) (
  input  logic          clk,
  input  logic          reset,
  motor_guard_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DEAD    = 3'd2,
    ST_FAULT   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_BWD  = 2'b10;

  localparam int TMAX = (DEADTIME_CYCLES > COOLDOWN_CYCLES) ? DEADTIME_CYCLES : COOLDOWN_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam int FW   = $clog2(FILTER_CYCLES + 1);
  localparam int RW   = $clog2(MAX_RETRIES + 1);

  state_e        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          sync_a_q, sync_b_q;
  logic          oc_now_q;
  logic          ena_q, enb_q, fault_q, lockout_q;
  logic [3:0]    hb_q, hb_d;
  logic [1:0]    cmd;
  logic          oc_flt;
  logic          enter_fault;
  logic [RW-1:0] retry_inc;

  // Each comparator gets its own first stage; the OR is taken into the shared second stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_q  <= 1'b0;
      sync_b_q  <= 1'b0;
      oc_now_q  <= 1'b0;
      flt_cnt_q <= '0;
    end else begin
      sync_a_q  <= bus.comp_a;
      sync_b_q  <= bus.comp_b;
      oc_now_q  <= sync_a_q | sync_b_q;
      flt_cnt_q <= flt_cnt_d;
    end
  end

  always_comb begin
    flt_cnt_d = '0;
    if (oc_now_q) begin
      flt_cnt_d = (flt_cnt_q == FW'(FILTER_CYCLES)) ? flt_cnt_q : flt_cnt_q + 1'b1;
    end
  end

  assign oc_flt = (flt_cnt_q == FW'(FILTER_CYCLES));

  always_comb begin
    cmd = DIR_NONE;
    if (bus.en_sw && bus.fwd_sw && !bus.bwd_sw) begin
      cmd = DIR_FWD;
    end else if (bus.en_sw && bus.bwd_sw && !bus.fwd_sw) begin
      cmd = DIR_BWD;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    tmr_d       = tmr_q;
    retry_d     = retry_q;
    enter_fault = 1'b0;
    retry_inc   = retry_q + 1'b1;
    hb_d        = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (!oc_flt && cmd != DIR_NONE) begin
          state_d = ST_RUN;
          dir_d   = cmd;
        end
      end
      ST_RUN: begin
        if (oc_flt) begin
          enter_fault = 1'b1;
        end else if (cmd != dir_q) begin
          state_d = ST_DEAD;
          tmr_d   = TW'(DEADTIME_CYCLES - 1);
        end
      end
      ST_DEAD: begin
        if (oc_flt) begin
          enter_fault = 1'b1;
        end else if (tmr_q == '0) begin
          if (cmd == DIR_NONE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
            dir_d   = cmd;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_FAULT: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (!bus.en_sw) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_fault) begin
      retry_d = retry_inc;
      tmr_d   = TW'(COOLDOWN_CYCLES - 1);
      state_d = (retry_inc >= RW'(MAX_RETRIES)) ? ST_LOCKOUT : ST_FAULT;
    end
    if (!bus.en_sw) begin
      retry_d = '0;
    end

    // The direction register only ever holds a real direction while driving.
    if (state_d != ST_RUN) begin
      dir_d = DIR_NONE;
    end
    case (dir_d)
      DIR_FWD: hb_d = 4'b1001;
      DIR_BWD: hb_d = 4'b0110;
      default: hb_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_NONE;
      tmr_q     <= '0;
      retry_q   <= '0;
      hb_q      <= 4'b0000;
      ena_q     <= 1'b0;
      enb_q     <= 1'b0;
      fault_q   <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      tmr_q     <= tmr_d;
      retry_q   <= retry_d;
      hb_q      <= hb_d;
      ena_q     <= (state_d == ST_RUN) && bus.pulse;
      enb_q     <= (state_d == ST_RUN) && bus.pulse;
      fault_q   <= (state_d == ST_FAULT);
      lockout_q <= (state_d == ST_LOCKOUT);
    end
  end

  assign bus.ena     = ena_q;
  assign bus.enb     = enb_q;
  assign bus.hb_in   = hb_q;
  assign bus.state   = state_q;
  assign bus.dir     = dir_q;
  assign bus.oc_now  = oc_now_q;
  assign bus.fault   = fault_q;
  assign bus.lockout = lockout_q;

endmodule

// File: tb/tb_motor_guard.sv
// Directed bench for motor_guard with short dead-time, filter and cooldown values.
module tb_motor_guard;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_DEAD = 3'd2;
  localparam logic [2:0] S_FLT  = 3'd3;
  localparam logic [2:0] S_LOCK = 3'd4;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  motor_guard_if bus();

  motor_guard #(
    .DEADTIME_CYCLES(4),
    .FILTER_CYCLES  (3),
    .COOLDOWN_CYCLES(10),
    .MAX_RETRIES    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] st, input logic [1:0] d,
                            input logic [3:0] hb, input logic en);
    check({tag, ".state"},   32'(bus.state),   32'(st));
    check({tag, ".dir"},     32'(bus.dir),     32'(d));
    check({tag, ".hb_in"},   32'(bus.hb_in),   32'(hb));
    check({tag, ".ena"},     32'(bus.ena),     32'(en));
    check({tag, ".enb"},     32'(bus.enb),     32'(en));
    check({tag, ".fault"},   32'(bus.fault),   32'(st == S_FLT));
    check({tag, ".lockout"}, 32'(bus.lockout), 32'(st == S_LOCK));
  endtask

  task automatic fault_burst(input string tag, input bit use_a);
    if (use_a) bus.comp_a = 1'b1; else bus.comp_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, ".pre"}, 32'(bus.state), 32'(S_RUN));
    end
    bus.comp_a = 1'b0;
    bus.comp_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check({tag, ".filt"}, 32'(bus.state), 32'(S_RUN));
    end
  endtask

  task automatic cooldown(input string tag, input logic [1:0] d, input logic [3:0] hb);
    for (int i = 0; i < 9; i++) begin
      step();
      expect_out({tag, ".cool"}, S_FLT, 2'b00, 4'b0000, 1'b0);
    end
    step();
    expect_out({tag, ".idle"}, S_IDLE, 2'b00, 4'b0000, 1'b0);
    step();
    expect_out({tag, ".rerun"}, S_RUN, d, hb, 1'b1);
  endtask

  initial begin
    vec_cnt     = 0;
    err_cnt     = 0;
    reset       = 1'b1;
    bus.pulse   = 1'b0;
    bus.en_sw   = 1'b0;
    bus.fwd_sw  = 1'b0;
    bus.bwd_sw  = 1'b0;
    bus.comp_a  = 1'b0;
    bus.comp_b  = 1'b0;

    // Reset held while every input toggles.
    for (int i = 0; i < 6; i++) begin
      bus.pulse  = 1'($urandom_range(0, 1));
      bus.en_sw  = 1'($urandom_range(0, 1));
      bus.fwd_sw = 1'($urandom_range(0, 1));
      bus.bwd_sw = 1'($urandom_range(0, 1));
      bus.comp_a = 1'($urandom_range(0, 1));
      bus.comp_b = 1'($urandom_range(0, 1));
      step();
      expect_out("rst", S_IDLE, 2'b00, 4'b0000, 1'b0);
      check("rst.oc_now", 32'(bus.oc_now), 32'd0);
    end
    bus.pulse  = 1'b0;
    bus.en_sw  = 1'b0;
    bus.fwd_sw = 1'b0;
    bus.bwd_sw = 1'b0;
    bus.comp_a = 1'b0;
    bus.comp_b = 1'b0;
    reset      = 1'b0;
    step();
    step();
    expect_out("idle", S_IDLE, 2'b00, 4'b0000, 1'b0);

    // Forward start, enables follow pulse one cycle late.
    bus.en_sw  = 1'b1;
    bus.fwd_sw = 1'b1;
    bus.pulse  = 1'b1;
    step();
    expect_out("start", S_RUN, 2'b01, 4'b1001, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bus.pulse = 1'(i % 2);
      step();
      expect_out("pwm", S_RUN, 2'b01, 4'b1001, 1'(i % 2));
    end
    bus.pulse = 1'b1;

    // Reversal through exactly four dead cycles.
    bus.fwd_sw = 1'b0;
    bus.bwd_sw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("rev_dead", S_DEAD, 2'b00, 4'b0000, 1'b0);
    end
    step();
    expect_out("rev_run", S_RUN, 2'b10, 4'b0110, 1'b1);

    // Two-cycle glitch on comp_a stays below the filter.
    bus.comp_a = 1'b1;
    step();
    step();
    check("glitch.oc_now", 32'(bus.oc_now), 32'd1);
    bus.comp_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("glitch.state", 32'(bus.state), 32'(S_RUN));
    end
    check("glitch.oc_clr", 32'(bus.oc_now), 32'd0);

    // First real fault, cooldown, automatic retry.
    fault_burst("flt1", 1'b0);
    step();
    expect_out("flt1", S_FLT, 2'b00, 4'b0000, 1'b0);
    cooldown("flt1", 2'b10, 4'b0110);

    // Second fault without releasing en_sw locks out.
    fault_burst("flt2", 1'b1);
    step();
    expect_out("lock", S_LOCK, 2'b00, 4'b0000, 1'b0);
    bus.fwd_sw = 1'b1;
    bus.bwd_sw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("lock_hold", S_LOCK, 2'b00, 4'b0000, 1'b0);
    end
    bus.en_sw = 1'b0;
    step();
    expect_out("unlock", S_IDLE, 2'b00, 4'b0000, 1'b0);
    bus.en_sw = 1'b1;
    step();
    expect_out("restart", S_RUN, 2'b01, 4'b1001, 1'b1);

    // Retry count was cleared, and a command change coinciding with the fault loses to it.
    fault_burst("flt3", 1'b0);
    bus.fwd_sw = 1'b0;
    bus.bwd_sw = 1'b1;
    step();
    expect_out("flt3", S_FLT, 2'b00, 4'b0000, 1'b0);
    cooldown("flt3", 2'b10, 4'b0110);

    // Both direction switches set is a stop request.
    bus.fwd_sw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("stop_dead", S_DEAD, 2'b00, 4'b0000, 1'b0);
    end
    step();
    expect_out("stop_idle", S_IDLE, 2'b00, 4'b0000, 1'b0);
    step();
    expect_out("stop_stay", S_IDLE, 2'b00, 4'b0000, 1'b0);

    // Reset in the middle of a dead-time window.
    bus.fwd_sw = 1'b0;
    step();
    expect_out("pre_rst", S_RUN, 2'b10, 4'b0110, 1'b1);
    bus.bwd_sw = 1'b0;
    bus.fwd_sw = 1'b1;
    step();
    step();
    expect_out("mid_dead", S_DEAD, 2'b00, 4'b0000, 1'b0);
    reset = 1'b1;
    step();
    expect_out("dead_rst", S_IDLE, 2'b00, 4'b0000, 1'b0);
    reset     = 1'b0;
    bus.en_sw = 1'b0;
    step();
    expect_out("final", S_IDLE, 2'b00, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/motor_guard.md
# motor_guard

Output stage between the PWM generator and the JA header. Takes the PWM `pulse`, the operator switches and the two overcurrent comparators, and drives the H-bridge direction pins and enable pins. Enforces a dead-time on every direction change or stop, and cuts drive on filtered overcurrent. Retries after a cooldown and latches a lockout after repeated faults. Exposes state and status for the seven-segment display.

## Interface
Parameters:
- `DEADTIME_CYCLES`, 100000: cycles the bridge is held off (1 ms at 100 MHz) on reversal or stop.
- `FILTER_CYCLES`, 8: consecutive synchronised overcurrent cycles required to declare a fault (≥1).
- `COOLDOWN_CYCLES`, 50000000: cycles held in FAULT before retry.
- `MAX_RETRIES`, 3: fault entries that trigger LOCKOUT instead of FAULT (≥1).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `pulse`  in  1  PWM output of the PWM stage.
- `en_sw`  in  1  primary enable switch (sw[0]).
- `fwd_sw`  in  1  forward request (sw[1]).
- `bwd_sw`  in  1  backward request (sw[2]).
- `comp_a`, `comp_b`  in  1 each  asynchronous overcurrent comparators (JA[0], JA[1]); high = over limit.
- `ena`, `enb`  out  1 each  bridge enables (JA[2], JA[3]).
- `hb_in`  out  4  bridge inputs; bit0=IN1 … bit3=IN4 (JA[4..7]).
- `state`  out  3  current state encoding.
- `dir`  out  2  applied direction: 00 none, 01 forward, 10 backward.
- `oc_now`  out  1  synchronised `comp_a|comp_b`, unfiltered.
- `fault`  out  1  high while in FAULT.
- `lockout`  out  1  high while in LOCKOUT.

## Operation
- Command decode: `cmd`=FWD if en_sw&fwd_sw&~bwd_sw; BWD if en_sw&bwd_sw&~fwd_sw; else NONE (both set = NONE).
- Bridge patterns: FWD `hb_in`=4'b1001, BWD 4'b0110, off 4'b0000. `hb_in` is never any other value.
- Overcurrent path: each comparator passes through a 2-FF synchroniser. `oc_now` = OR of the synced bits. A saturating counter increments while `oc_now`=1 and clears on any cycle `oc_now`=0. `oc_flt` asserts when the count reaches FILTER_CYCLES.
- States: IDLE=0, RUN=1, DEAD=2, FAULT=3, LOCKOUT=4.
- IDLE: bridge off, `dir`=00. If oc_flt, stay in IDLE. Else, if cmd≠NONE, go to RUN with `dir`=cmd.
- RUN: `hb_in`=pattern(dir); `ena`=`enb`=`pulse` registered. If oc_flt, go to FAULT (highest priority). Else, if cmd≠dir, go to DEAD and load the dead-time counter.
- DEAD: bridge off, enables 0, `dir`=00. Counts DEADTIME_CYCLES cycles. If oc_flt, go to FAULT. At terminal count: if cmd=NONE, go to IDLE; else go to RUN with `dir`=cmd (cmd sampled at the terminal-count cycle).
- FAULT entry: increment the retry count. If the new count ≥ MAX_RETRIES, go to LOCKOUT instead of FAULT.
- FAULT: bridge off. Counts COOLDOWN_CYCLES cycles, then goes to IDLE. `en_sw` is ignored until the count expires.
- LOCKOUT: bridge off. Held until `en_sw`=0, then goes to IDLE.
- Retry count clears on reset and on any cycle with `en_sw`=0. It is not cleared by `cmd` alone.
- Every output is a register. Enables are nonzero only in RUN.

## Timing
- Reset values: `ena`=`enb`=0, `hb_in`=0000, `state`=0, `dir`=00, `oc_now`=0, `fault`=0, `lockout`=0. All counters are 0.
- `ena`/`enb` lag `pulse` by exactly 1 cycle in RUN.
- IDLE to drive: the cycle after cmd≠NONE is sampled, `state`=RUN and `hb_in` holds the pattern.
- Overcurrent: `comp` held high from edge k gives `ena`=`enb`=0 at edge k+FILTER_CYCLES+3 at the latest.
- Reversal: `hb_in`=0000 for exactly DEADTIME_CYCLES cycles, then the new pattern. The two patterns are never adjacent.
- Simultaneous oc_flt and cmd change in RUN: FAULT wins.
- Reset mid-DEAD, FAULT or LOCKOUT: the next cycle is IDLE with all outputs at reset values.

## Test plan
Use DEADTIME_CYCLES=4, FILTER_CYCLES=3, COOLDOWN_CYCLES=10, MAX_RETRIES=2.
- Reset asserted with all inputs toggling -> every output at its reset value for as long as reset is held.
- en_sw=1, fwd_sw=1, `pulse` square wave -> `state`=1 one cycle later; `hb_in`=1001; `ena`/`enb` equal `pulse` delayed 1 cycle.
- In RUN forward, switch to bwd_sw only -> `hb_in`=0000 and enables 0 for exactly 4 cycles; then `hb_in`=0110 and `dir`=10.
- `comp_a` high for 2 cycles -> no state change. `comp_b` high for 3 cycles -> `state`=3, `fault`=1 and enables 0 within 6 edges. After 10 cycles -> IDLE, then RUN.
- Second fault without dropping en_sw -> `lockout`=1 and held with fwd_sw=1. Drop en_sw for 1 cycle -> IDLE, `lockout`=0, retry count cleared.
- In RUN, set fwd_sw=bwd_sw=1 -> DEAD for 4 cycles, then IDLE with `dir`=00.
